// File: rtl/sync_fifo_flags.sv
// Single-clock FWFT FIFO of arbitrary depth with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 6,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             err_clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    output logic             almost_full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             almost_empty_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int            IW        = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_TH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc, rd_acc;

    // Indices wrap explicitly at DEPTH-1 so non-power-of-2 depths never overrun.
    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IW'(1);
    endfunction

    assign full_o         = (count_q == DEPTH_C);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
    assign rd_data_o      = mem_q[rd_idx_q];

    assign wr_acc = wr_en_i && (!full_o || rd_en_i);
    assign rd_acc = rd_en_i && !empty_o;

    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        ovf_d    = ovf_q && !err_clr_i;
        unf_d    = unf_q && !err_clr_i;
        if (flush_i) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_idx_d = idx_inc(wr_idx_q);
            if (rd_acc) rd_idx_d = idx_inc(rd_idx_q);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // Set dominates a same-cycle clear.
            if (wr_en_i && !wr_acc) ovf_d = 1'b1;
            if (rd_en_i && !rd_acc) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage carries no reset; contents survive flush and reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush_i) mem_q[wr_idx_q] <= wr_data_i;
    end

endmodule
